bcd_counter_scan: RTL and testbench
===================================

# bcd_counter_scan

Four-digit BCD up/down counter with built-in display scan multiplexer. It counts decimal 0000–9999 at a prescaled tick rate. It time-multiplexes the four digits onto one shared 4-bit BCD bus plus four active-low digit enables. It sits directly upstream of the BCD-to-7-segment decoder: `bcd` drives the decoder input, and `an` drives the common-anode digit selects of the display.

## Interface
Parameters:
- `CNT_DIV`, default 50_000_000: clock cycles per count tick (1 Hz at 50 MHz). Legal range ≥1.
- `SCAN_DIV`, default 50_000: clock cycles each digit stays selected (1 kHz per digit at 50 MHz). Legal range ≥1.

Ports:
- `clk`, input, 1: single system clock. All state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `en`, input, 1: count enable. When low, the count prescaler and the digits hold.
- `up`, input, 1: count direction. 1 = increment, 0 = decrement. Sampled on the tick cycle.
- `clr`, input, 1: synchronous clear of the digits and the count prescaler.
- `count`, output, 16: packed digits {d3,d2,d1,d0}, 4 bits each, d0 = units.
- `bcd`, output, 4: digit currently selected by the scan, for the 7-seg decoder.
- `an`, output, 4: active-low one-hot digit enable. `an[i]` = 0 selects digit i.
- `wrap`, output, 1: one-cycle pulse on a 9999→0000 or 0000→9999 transition.

## Operation
- Clock and reset: one clock, `clk`. Reset is synchronous, active-high on `rst`. No other asynchronous paths.
- Priority: `rst` > `clr` > tick.
- Reset values:
  - `count` = 16'h0000, `bcd` = 4'h0, `an` = 4'b1110, `wrap` = 0.
  - Both prescalers = 0. Scan index = 0.
- Count prescaler:
  - Width is `$clog2(CNT_DIV)` (minimum 1).
  - Advances only when `en` = 1. When it reaches `CNT_DIV`-1 it returns to 0 and asserts an internal tick for that cycle.
  - `CNT_DIV` = 1 gives a tick on every enabled cycle.
- Tick, increment (`up` = 1):
  - d0 += 1. A digit at 9 goes to 0 and carries into the next digit.
  - 9999 → 0000 asserts `wrap`.
- Tick, decrement (`up` = 0):
  - d0 −= 1. A digit at 0 goes to 9 and borrows from the next digit.
  - 0000 → 9999 asserts `wrap`.
- Digit range: each digit always stays within 0–9. Codes A–F are never produced.
- `clr`:
  - Zeroes the digits and the count prescaler.
  - Suppresses any tick in the same cycle, and `wrap` = 0.
  - The scan logic is unaffected.
- `en` low: digits and count prescaler hold. `clr` still acts.
- Scan prescaler:
  - Free-running regardless of `en`. Counts 0..`SCAN_DIV`-1.
  - At terminal count the scan index advances 0→1→2→3→0.
- Scan outputs:
  - `an` = ~(1 << index): 1110, 1101, 1011, 0111.
  - `bcd` = digit[index].
  - Both are registered together, so they are always mutually consistent. No glitch is allowed where `an` and `bcd` mismatch.

## Timing
- `count` and `wrap`:
  - Both update on the clock edge that ends the tick cycle.
  - Latency from the first enabled cycle to the first tick: exactly `CNT_DIV` enabled cycles.
  - `wrap` is high for exactly one cycle.
- `an`/`bcd`:
  - Both change on the edge following the scan terminal count. Each selection is held exactly `SCAN_DIV` cycles.
  - A count change while a digit is selected appears on `bcd` one cycle after `count` changes. The registered sample is taken from the new `count`.
- `up` toggled between ticks: only the value present on the tick cycle matters.
- `rst` asserted mid-count or mid-scan: on the next edge all outputs take their reset values, regardless of other inputs.
- `clr` released: the next tick occurs `CNT_DIV` enabled cycles later.

## Test plan
All scenarios use `CNT_DIV` = 4 and `SCAN_DIV` = 2.
1. Reset: hold `rst` = 1 for 2 cycles with random other inputs → `count` = 0000, `an` = 1110, `bcd` = 0, `wrap` = 0.
2. Up count: `en` = 1, `up` = 1 → `count` steps every 4 cycles: 0000, 0001, …, 0009, 0010 (decimal carry). After 100 ticks `count` = 0100.
3. Wrap:
   - From 0000 with `up` = 0, one tick → `count` = 9999 and `wrap` pulses exactly 1 cycle.
   - Then with `up` = 1, one tick → `count` = 0000 and `wrap` pulses again.
4. Hold and clear:
   - Drop `en` for 10 cycles mid-prescale → `count` is unchanged, and the tick resumes after the remaining enabled cycles.
   - Assert `clr` in a tick cycle → `count` = 0000 and `wrap` = 0. The next tick comes 4 enabled cycles later.
5. Scan: freeze `count` = 1234 (`en` = 0) → `an`/`bcd` cycle through 1110/4, 1101/3, 1011/2, 0111/1, then back to 1110/4. Each pair is held exactly 2 cycles.
6. Mid-operation reset: assert `rst` during scan index 2 with the count prescaler at 3 → next edge gives reset values. The first tick occurs 4 cycles after `rst` deasserts.

Source files
------------

// File: rtl/bcd_counter_scan.sv
// Four-digit BCD up/down counter with a prescaled count tick and a
// time-multiplexed digit scan for a common-anode 7-segment display.
module bcd_counter_scan #(
  parameter int CNT_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  output logic [15:0] count,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        wrap
);

  localparam int CW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_pre_q, cnt_pre_d;
  logic [SW-1:0] scan_pre_q, scan_pre_d;
  logic [15:0]   count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          wrap_q, wrap_d;
  logic          tick;

  // Ripple a +1 / -1 through the four decimal digits.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic inc);
    logic [15:0] r;
    logic        carry;
    logic [3:0]  d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (inc) begin
          if (d >= 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (d == 4'd0 || d > 4'd9) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Count path: clr overrides the tick, en gates the prescaler.
  always_comb begin
    tick      = en && (cnt_pre_q == CNT_LAST) && !clr;
    cnt_pre_d = cnt_pre_q;
    count_d   = count_q;
    wrap_d    = 1'b0;
    if (clr) begin
      cnt_pre_d = '0;
      count_d   = 16'h0000;
    end else if (en) begin
      if (tick) begin
        cnt_pre_d = '0;
        count_d   = bcd_step(count_q, up);
        wrap_d    = up ? (count_q == 16'h9999) : (count_q == 16'h0000);
      end else begin
        cnt_pre_d = cnt_pre_q + CW'(1);
      end
    end
  end

  // Scan path: free-running; an and bcd come from the same next index.
  always_comb begin
    scan_pre_d = scan_pre_q + SW'(1);
    idx_d      = idx_q;
    if (scan_pre_q == SCAN_LAST) begin
      scan_pre_d = '0;
      idx_d      = idx_q + 2'd1;
    end
    an_d = ~(4'b0001 << idx_d);
    case (idx_d)
      2'd0:    bcd_d = count_q[3:0];
      2'd1:    bcd_d = count_q[7:4];
      2'd2:    bcd_d = count_q[11:8];
      default: bcd_d = count_q[15:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_pre_q  <= '0;
      scan_pre_q <= '0;
      count_q    <= 16'h0000;
      idx_q      <= 2'd0;
      an_q       <= 4'b1110;
      bcd_q      <= 4'h0;
      wrap_q     <= 1'b0;
    end else begin
      cnt_pre_q  <= cnt_pre_d;
      scan_pre_q <= scan_pre_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      bcd_q      <= bcd_d;
      wrap_q     <= wrap_d;
    end
  end

  assign count = count_q;
  assign bcd   = bcd_q;
  assign an    = an_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Randomized bench for bcd_counter_scan against a decimal-integer reference model.
module tb_bcd_counter_scan;

  localparam int CNT_DIV  = 4;
  localparam int SCAN_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        up  = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] count;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        wrap;
  logic [24:0] obs;

  bcd_counter_scan #(.CNT_DIV(CNT_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .count(count), .bcd(bcd), .an(an), .wrap(wrap)
  );

  always #5 clk = ~clk;
  assign obs = {count, an, bcd, wrap};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: value as an integer, enabled-cycle counter, cycles since reset.
  int         m_val = 0;
  int         m_pre = 0;
  int         m_st  = 0;
  bit         m_wrap = 1'b0;
  logic [3:0] m_an  = 4'b1110;
  logic [3:0] m_bcd = 4'h0;

  function automatic int digit_of(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(digit_of(v, 3)), 4'(digit_of(v, 2)), 4'(digit_of(v, 1)), 4'(digit_of(v, 0))};
  endfunction

  function automatic logic [24:0] exp_vec();
    return {to_bcd(m_val), m_an, m_bcd, m_wrap};
  endfunction

  function automatic int m_idx();
    return (m_st / SCAN_DIV) % 4;
  endfunction

  task automatic model_step();
    int old;
    if (rst) begin
      m_val = 0; m_pre = 0; m_st = 0; m_wrap = 1'b0;
      m_an = 4'b1110; m_bcd = 4'h0;
    end else begin
      old    = m_val;
      m_st   = m_st + 1;
      m_an   = ~(4'b0001 << m_idx());
      m_bcd  = 4'(digit_of(old, m_idx()));
      m_wrap = 1'b0;
      if (clr) begin
        m_val = 0; m_pre = 0;
      end else if (en) begin
        m_pre = m_pre + 1;
        if (m_pre == CNT_DIV) begin
          m_pre = 0;
          if (up) begin
            m_wrap = (m_val == 9999);
            m_val  = (m_val + 1) % 10000;
          end else begin
            m_wrap = (m_val == 0);
            m_val  = (m_val + 9999) % 10000;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); up = 1'($urandom); clr = 1'($urandom);
      cycle();
      if (i == 1) begin
        if (obs !== {16'h0000, 4'b1110, 4'h0, 1'b0}) begin
          n_err++; $display("FAIL reset_values: got %h required %h", obs, {16'h0000, 4'b1110, 4'h0, 1'b0});
        end
        n_vec++;
      end
    end
    rst = 1'b0; en = 1'b0; clr = 1'b0;
  endtask

  task automatic test_up_count();
    en = 1'b1; up = 1'b1; clr = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      cycle();
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL up_count cyc %0d: got %h required %h", i, obs, exp_vec());
      end
      n_vec++;
      if (i == 40) begin
        if (count !== 16'h0010) begin
          n_err++; $display("FAIL up_count_carry: got %h required 0010", count);
        end
        n_vec++;
      end
    end
    if (count !== 16'h0100) begin
      n_err++; $display("FAIL up_count_100: got %h required 0100", count);
    end
    n_vec++;
  endtask

  task automatic test_wrap();
    clr = 1'b1; en = 1'b1;
    cycle();
    clr = 1'b0; up = 1'b0;
    for (int i = 0; i < CNT_DIV; i++) begin
      cycle();
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL wrap_down cyc %0d: got %h required %h", i, obs, exp_vec());
      end
      n_vec++;
    end
    if ({count, wrap} !== {16'h9999, 1'b1}) begin
      n_err++; $display("FAIL wrap_to_9999: got %h/%b required 9999/1", count, wrap);
    end
    n_vec++;
    up = 1'b1;
    cycle();
    if ({count, wrap} !== {16'h9999, 1'b0}) begin
      n_err++; $display("FAIL wrap_pulse_width: got %h/%b required 9999/0", count, wrap);
    end
    n_vec++;
    for (int i = 0; i < CNT_DIV - 1; i++) cycle();
    if ({count, wrap} !== {16'h0000, 1'b1}) begin
      n_err++; $display("FAIL wrap_to_0000: got %h/%b required 0000/1", count, wrap);
    end
    n_vec++;
    cycle();
    if (wrap !== 1'b0) begin
      n_err++; $display("FAIL wrap_up_width: got %b required 0", wrap);
    end
    n_vec++;
  endtask

  task automatic test_hold_clear();
    int saved;
    int remaining;
    bit found;
    up = 1'b1; en = 1'b1; clr = 1'b0;
    cycle();
    saved = m_val;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs !== exp_vec() || count !== to_bcd(saved)) begin
        n_err++; $display("FAIL hold cyc %0d: got %h required %h", i, obs, exp_vec());
      end
      n_vec++;
    end
    en = 1'b1;
    remaining = CNT_DIV - m_pre;
    for (int i = 0; i < remaining - 1; i++) cycle();
    if (count !== to_bcd(saved)) begin
      n_err++; $display("FAIL hold_early_tick: got %h required %h", count, to_bcd(saved));
    end
    n_vec++;
    cycle();
    if (count !== to_bcd((saved + 1) % 10000)) begin
      n_err++; $display("FAIL hold_resume: got %h required %h", count, to_bcd((saved + 1) % 10000));
    end
    n_vec++;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_pre == CNT_DIV - 1) found = 1'b1;
      else cycle();
    end
    if (!found) begin
      n_err++; $display("FAIL clr_setup: prescaler alignment not reached, got %0d required %0d", m_pre, CNT_DIV - 1);
    end
    n_vec++;
    clr = 1'b1;
    cycle();
    if ({count, wrap} !== {16'h0000, 1'b0}) begin
      n_err++; $display("FAIL clr_in_tick: got %h/%b required 0000/0", count, wrap);
    end
    n_vec++;
    clr = 1'b0;
    for (int i = 0; i < CNT_DIV - 1; i++) cycle();
    if (count !== 16'h0000) begin
      n_err++; $display("FAIL clr_early_tick: got %h required 0000", count);
    end
    n_vec++;
    cycle();
    if (count !== 16'h0001) begin
      n_err++; $display("FAIL clr_next_tick: got %h required 0001", count);
    end
    n_vec++;
  endtask

  task automatic test_scan();
    logic [3:0] prev_an;
    logic [3:0] want;
    int run;
    bit started;
    clr = 1'b1; en = 1'b1; up = 1'b1;
    cycle();
    clr = 1'b0;
    for (int i = 0; i < 1234 * CNT_DIV; i++) begin
      cycle();
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL scan_load cyc %0d: got %h required %h", i, obs, exp_vec());
      end
      n_vec++;
    end
    en = 1'b0;
    cycle();
    prev_an = an; run = 1; started = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      case (an)
        4'b1110: want = 4'h4;
        4'b1101: want = 4'h3;
        4'b1011: want = 4'h2;
        4'b0111: want = 4'h1;
        default: want = 4'hx;
      endcase
      if (obs !== exp_vec() || bcd !== want) begin
        n_err++; $display("FAIL scan_pair cyc %0d: got an=%b bcd=%h required an=%b bcd=%h", i, an, bcd, m_an, m_bcd);
      end
      n_vec++;
      if (an !== prev_an) begin
        if (started) begin
          if (run !== SCAN_DIV || an !== {prev_an[2:0], prev_an[3]}) begin
            n_err++; $display("FAIL scan_hold: got run %0d an %b required run %0d an %b", run, an, SCAN_DIV, {prev_an[2:0], prev_an[3]});
          end
          n_vec++;
        end
        started = 1'b1; run = 1; prev_an = an;
      end else begin
        run++;
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found = 1'b0;
    up = 1'b1; clr = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      en = 1'($urandom);
      cycle();
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL mid_reset_run cyc %0d: got %h required %h", i, obs, exp_vec());
      end
      n_vec++;
      if (m_idx() == 2 && m_pre == CNT_DIV - 1) found = 1'b1;
    end
    if (!found) begin
      n_err++; $display("FAIL mid_reset_setup: got idx %0d pre %0d required idx 2 pre %0d", m_idx(), m_pre, CNT_DIV - 1);
    end
    n_vec++;
    rst = 1'b1; en = 1'($urandom); up = 1'($urandom); clr = 1'($urandom);
    cycle();
    if (obs !== {16'h0000, 4'b1110, 4'h0, 1'b0}) begin
      n_err++; $display("FAIL mid_reset_values: got %h required %h", obs, {16'h0000, 4'b1110, 4'h0, 1'b0});
    end
    n_vec++;
    rst = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0;
    for (int i = 0; i < CNT_DIV - 1; i++) cycle();
    if (count !== 16'h0000) begin
      n_err++; $display("FAIL mid_reset_early_tick: got %h required 0000", count);
    end
    n_vec++;
    cycle();
    if ({count, wrap} !== {16'h0001, 1'b0}) begin
      n_err++; $display("FAIL mid_reset_first_tick: got %h/%b required 0001/0", count, wrap);
    end
    n_vec++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 3) != 0);
      up  = 1'($urandom);
      cycle();
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL random cyc %0d: got %h required %h", i, obs, exp_vec());
      end
      n_vec++;
    end
    rst = 1'b0; clr = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap();
    test_hold_clear();
    test_scan();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
